// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths and FSM encoding for the synth tone-path arithmetic blocks
package synth_pkg;

  localparam int COUNT_W = 16;
  localparam int FRAC_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - shift-add multiplier, product = floor(multiplicand * factor / 256)
import synth_pkg::*;

module sequential_multiplier #(
  parameter int MCAND_W = COUNT_W,
  parameter int FACT_W  = FRAC_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [MCAND_W-1:0] multiplicand,
  input  logic [FACT_W-1:0]  factor,
  output logic [MCAND_W-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int ACC_W = MCAND_W + FACT_W;
  localparam int CNT_W = $clog2(FACT_W);

  mult_state_t        r_state;
  logic [MCAND_W-1:0] r_a;
  logic [FACT_W-1:0]  r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [MCAND_W-1:0] r_product;
  logic               r_done;

  logic [ACC_W-1:0]   w_a_ext;
  logic [ACC_W-1:0]   w_addend;
  logic               w_last;

  assign w_a_ext  = {{FACT_W{1'b0}}, r_a};
  assign w_addend = r_b[r_cnt] ? (w_a_ext << r_cnt) : '0;
  assign w_last   = (r_cnt == CNT_W'(FACT_W - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_a     <= multiplicand;
            r_b     <= factor;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // Dropping en discards the partial sum; product keeps its old value.
          if (!en) begin
            r_state <= IDLE;
          end else begin
            r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (!en) begin
            r_state <= IDLE;
          end else begin
            r_product <= r_acc[ACC_W-1:FACT_W];
            r_done    <= 1'b1;
            r_a       <= multiplicand;
            r_b       <= factor;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= BUSY;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - directed self-checking bench for sequential_multiplier
module tb_sequential_multiplier;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [15:0] multiplicand;
  logic [7:0]  factor;
  logic [15:0] product;
  logic        done;
  logic        busy;

  int errors;
  int checks;
  int n;
  int pulses;

  sequential_multiplier dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .multiplicand (multiplicand),
    .factor       (factor),
    .product      (product),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until done is seen, bounded at 40.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
  endtask

  task automatic run_vec(input string tag, input logic [15:0] mc, input logic [7:0] f,
                         input logic [15:0] exp);
    int c;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    multiplicand = mc;
    factor       = f;
    en           = 1'b1;
    wait_done(c);
    check({tag, "_latency"}, c, 10);
    check({tag, "_product"}, product, exp);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    nrst         = 1'b0;
    en           = 1'b1;
    multiplicand = 16'd22727;
    factor       = 8'd255;

    // Power-on reset held for two clocks
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_product", product, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
    end
    nrst = 1'b1;
    #1;
    check("rel_product", product, 0);
    check("rel_busy", busy, 0);
    en = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Standard case, then free-running repeat
    multiplicand = 16'd22727;
    factor       = 8'd247;
    en           = 1'b1;
    wait_done(n);
    check("std_latency", n, 10);
    check("std_product", product, 21928);
    @(negedge clk);
    check("std_pulse_width", done, 0);
    check("std_busy", busy, 1);
    wait_done(n);
    check("std_repeat_latency", n, 8);
    check("std_repeat_product", product, 21928);

    // Max and min factors, max operands
    run_vec("f255", 16'd22727, 8'd255, 16'd22638);
    run_vec("f0", 16'd22727, 8'd0, 16'd0);
    run_vec("max", 16'd65535, 8'd255, 16'd65279);

    // Operand change mid-operation affects only the next load
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    multiplicand = 16'd22727;
    factor       = 8'd247;
    en           = 1'b1;
    repeat (3) @(negedge clk);
    factor = 8'd1;
    wait_done(n);
    check("midop_latency", n, 7);
    check("midop_product", product, 21928);
    wait_done(n);
    check("midop_next_latency", n, 9);
    check("midop_next_product", product, 88);

    // Abort during BUSY
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    multiplicand = 16'd1000;
    factor       = 8'd128;
    en           = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 88);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_hold", product, 88);
    en = 1'b1;
    wait_done(n);
    check("abort_rerun_latency", n, 10);
    check("abort_rerun_product", product, 500);

    // Reset in the middle of BUSY
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    multiplicand = 16'd22727;
    factor       = 8'd255;
    en           = 1'b1;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("midrst_product", product, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    nrst = 1'b1;
    wait_done(n);
    check("midrst_rerun_latency", n, 10);
    check("midrst_rerun_product", product, 22638);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
